// File: rtl/gear_accumulator_if.sv
// ============================================================================
// Module      : gear_accumulator_if
// Description : Bundles the run-control, sample-input and result-output
//               handshakes of gear_accumulator. The master drives runs and
//               samples and consumes results. The slave is the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gear_accumulator_if #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic [ACC_WIDTH-1:0] acc_init;
  logic                 exact;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output start, len, acc_init, exact, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  start, len, acc_init, exact, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/gear_accumulator.sv
// ============================================================================
// Module      : gear_accumulator
// Description : Accumulates a run of signed samples onto a seed value. Each
//               add is either exact or GeAr windowed-carry (R/P). The choice
//               is latched per run. The result leaves on a valid/ready
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gear_accumulator #(
  parameter int R         = 8,   // result bits per window after window 0
  parameter int P         = 8,   // overlap bits used for carry prediction
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,  // must satisfy ACC_WIDTH>=R+P, (ACC_WIDTH-P)%R==0
  parameter int LEN_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  gear_accumulator_if.slave  bus
);

  localparam int L = R + P;                    // window width
  localparam int K = 1 + (ACC_WIDTH - L) / R;  // number of windows

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 mode_q, mode_d;         // 1 = exact, 0 = GeAr
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [ACC_WIDTH-1:0] w_b;
  logic [ACC_WIDTH-1:0] w_sum_exact;
  logic [ACC_WIDTH-1:0] w_sum_gear;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_accept;

  assign w_b         = {{(ACC_WIDTH-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
  assign w_sum_exact = acc_q + w_b;
  assign w_sum       = mode_q ? w_sum_exact : w_sum_gear;
  // in_ready_q is high exactly while in ACCUM, so it qualifies the handshake.
  assign w_accept    = bus.in_valid && in_ready_q;

  // GeAr add: independent L-bit windows with carry-in 0. Window 0 yields its
  // full L bits. Each later window yields only its top R bits. Its low P bits
  // only predict the carry into that slice.
  always_comb begin
    logic [L-1:0] s;
    w_sum_gear = '0;
    for (int i = 0; i < K; i++) begin
      s = acc_q[i*R +: L] + w_b[i*R +: L];
      if (i == 0) begin
        w_sum_gear[L-1:0] = s;
      end else begin
        w_sum_gear[P + i*R +: R] = s[L-1:P];
      end
    end
  end

  // Next-state and next-output logic. Outputs are decoded from the next state
  // so that they become registered values aligned with the state.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.acc_init;
          count_d = bus.len;
          mode_d  = bus.exact;
          if (bus.len != '0) begin
            state_d = S_ACCUM;
          end else begin
            state_d    = S_DONE;
            out_data_d = bus.acc_init;
          end
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          acc_d   = w_sum;
          count_d = count_q - LEN_WIDTH'(1);
          if (count_q == LEN_WIDTH'(1)) begin
            state_d    = S_DONE;
            out_data_d = w_sum;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_ACCUM);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gear_accumulator.sv
// ============================================================================
// Module      : tb_gear_accumulator
// Description : Directed bench for gear_accumulator. It covers reset, exact
//               and GeAr runs, zero-length runs, backpressure, gapped input
//               and randomised runs against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gear_accumulator;

  localparam int R         = 8;
  localparam int P         = 8;
  localparam int IN_WIDTH  = 16;
  localparam int ACC_WIDTH = 32;
  localparam int LEN_WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gear_accumulator_if #(
    .IN_WIDTH (IN_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .LEN_WIDTH(LEN_WIDTH)
  ) bus ();

  gear_accumulator #(
    .R        (R),
    .P        (P),
    .IN_WIDTH (IN_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference add. The GeAr path uses shift-and-mask windows on wide integers.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [15:0] d,
                                            input logic ex);
    longint unsigned ua, ub, s, res;
    ua = 64'(a);
    ub = 64'({{16{d[15]}}, d});
    if (ex) return 32'(ua + ub);
    res = 0;
    for (int w = 0; w < 1 + (ACC_WIDTH - (R + P)) / R; w++) begin
      s = ((ua >> (w * R)) & 64'hFFFF) + ((ub >> (w * R)) & 64'hFFFF);
      s = s & 64'hFFFF;
      if (w == 0) res = res | s;
      else        res = res | (((s >> P) & 64'hFF) << (P + w * R));
    end
    return 32'(res);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start_run(input logic [31:0] init, input logic [7:0] n, input logic ex);
    bus.start    = 1'b1;
    bus.acc_init = init;
    bus.len      = n;
    bus.exact    = ex;
    step();
    bus.start = 1'b0;
    bus.exact = ~ex;  // must not affect the latched mode
  endtask

  task automatic send(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_idle_busy"},  32'(bus.busy),      32'd0);
    check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_acc;
    logic [31:0] held;
    logic [15:0] smp;
    int          n;
    logic        ex;

    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.acc_init = '0; bus.exact = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_out_data",  bus.out_data,       32'd0);

    // Exact run: 1 - 2 + 300 + 32767 = 33066.
    start_run(32'h0, 8'd4, 1'b1);
    check("t2_in_ready", 32'(bus.in_ready), 32'd1);
    check("t2_busy",     32'(bus.busy),     32'd1);
    send(16'h0001);
    send(16'hFFFE);
    send(16'd300);
    check("t2_no_early_valid", 32'(bus.out_valid), 32'd0);
    check("t2_ready_b2b",      32'(bus.in_ready),  32'd1);
    send(16'h7FFF);
    check("t2_valid",     32'(bus.out_valid), 32'd1);
    check("t2_data",      bus.out_data,       32'h0000_812A);
    check("t2_ready_low", 32'(bus.in_ready),  32'd0);
    drain("t2");

    // Carry crossing a window boundary: exact propagates, GeAr drops it.
    start_run(32'h00FF_FF80, 8'd1, 1'b1);
    send(16'h0080);
    check("t3_exact", bus.out_data, 32'h0100_0000);
    drain("t3e");
    start_run(32'h00FF_FF80, 8'd1, 1'b0);
    send(16'h0080);
    check("t3_gear", bus.out_data, 32'h00FF_0000);
    drain("t3g");

    // Zero-length run: result is the seed and nothing is accepted.
    start_run(32'h1234_5678, 8'd0, 1'b1);
    check("t4_valid",    32'(bus.out_valid), 32'd1);
    check("t4_in_ready", 32'(bus.in_ready),  32'd0);
    check("t4_data",     bus.out_data,       32'h1234_5678);
    bus.in_valid = 1'b1; bus.in_data = 16'h0101;
    step();
    bus.in_valid = 1'b0;
    check("t4_data_hold", bus.out_data, 32'h1234_5678);
    drain("t4");

    // Backpressure in DONE with a start pulse that must be ignored.
    // GeAr: 0x10 + 5 = 0x15; 0x15 + (-1) loses the upper-window carries.
    start_run(32'h0000_0010, 8'd2, 1'b0);
    send(16'h0005);
    send(16'hFFFF);
    check("t5_gear_data",  bus.out_data, 32'hFFFF_0014);
    check("t5_gear_model", bus.out_data,
          model_add(model_add(32'h10, 16'h5, 1'b0), 16'hFFFF, 1'b0));
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.start = 1'b1; bus.len = 8'd3; bus.acc_init = 32'h0000_DEAD; bus.exact = 1'b1;
      end
      step();
      bus.start = 1'b0;
      check("t5_valid_hold", 32'(bus.out_valid), 32'd1);
      check("t5_data_hold",  bus.out_data,       held);
      check("t5_ready_low",  32'(bus.in_ready),  32'd0);
    end
    drain("t5");
    step();
    check("t5_start_ignored", 32'(bus.busy), 32'd0);

    // Gapped input: valid pattern 1,0,1,0,1 accepts 10, 30, 50.
    start_run(32'd100, 8'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 16'(10 * (i + 1));
      step();
    end
    bus.in_valid = 1'b1; bus.in_data = 16'd999;
    check("t6_valid", 32'(bus.out_valid), 32'd1);
    check("t6_data",  bus.out_data,       32'd190);
    step();
    bus.in_valid = 1'b0;
    check("t6_no_extra_accept", bus.out_data, 32'd190);
    drain("t6");

    // Reset in the middle of a run discards it.
    start_run(32'h5555_0000, 8'd5, 1'b1);
    send(16'h0003);
    send(16'h0004);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t1_in_ready",  32'(bus.in_ready),  32'd0);
    check("t1_out_valid", 32'(bus.out_valid), 32'd0);
    check("t1_busy",      32'(bus.busy),      32'd0);
    check("t1_out_data",  bus.out_data,       32'd0);
    step();
    check("t1_still_idle", 32'(bus.busy), 32'd0);

    // Randomised runs checked against the reference model.
    for (int r = 0; r < 8; r++) begin
      exp_acc = $urandom;
      n       = $urandom_range(1, 6);
      ex      = 1'($urandom_range(0, 1));
      start_run(exp_acc, 8'(n), ex);
      for (int s = 0; s < n; s++) begin
        smp     = 16'($urandom);
        exp_acc = model_add(exp_acc, smp, ex);
        send(smp);
      end
      check("rand_valid", 32'(bus.out_valid), 32'd1);
      check("rand_data",  bus.out_data,       exp_acc);
      drain("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
